// File: rtl/fp_pkg.sv
// Shared binary32 types, constants, FSM encoding and operand classifiers
// for the floating-point arithmetic unit.
package fp_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    localparam int          EXP_BIAS = 127;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF  = 32'h7F80_0000;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        PACK = 2'd3
    } state_t;

    function automatic logic is_nan(input fp32_t x);
        return (x.exp == 8'hFF) && (x.man != 23'd0);
    endfunction

    function automatic logic is_inf(input fp32_t x);
        return (x.exp == 8'hFF) && (x.man == 23'd0);
    endfunction

    // A zero exponent covers true zeros and denormals, which are flushed to zero.
    function automatic logic is_zero(input fp32_t x);
        return (x.exp == 8'h00);
    endfunction

endpackage

// File: rtl/fp_div_mant.sv
// Bit-serial restoring significand divider: one quotient bit per cycle for
// ITER cycles after a start pulse.
module fp_div_mant #(
    parameter int ITER = 26
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [23:0]     dividend,
    input  logic [23:0]     divisor,
    output logic [ITER-1:0] quo,
    output logic            sticky,
    output logic            done
);

    localparam int            CW   = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    logic [24:0]   rem;
    logic [23:0]   dvs;
    logic [CW-1:0] cnt;
    logic          busy;
    logic          ge;
    logic [23:0]   nxt;

    // Both significands are normalised, so rem < 2*dvs and the restored value fits 24 bits.
    assign ge  = rem >= {1'b0, dvs};
    assign nxt = ge ? (rem[23:0] - dvs) : rem[23:0];

    // Flags the cycle in which the final quotient bit is being produced.
    assign done   = busy && (cnt == LAST);
    assign sticky = |rem;

    always_ff @(posedge clk) begin
        if (rstn) begin
            rem  <= '0;
            dvs  <= '0;
            quo  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            rem  <= {1'b0, dividend};
            dvs  <= divisor;
            quo  <= '0;
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            rem <= {nxt, 1'b0};
            quo <= {quo[ITER-2:0], ge};
            cnt <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fp_div.sv
// Free-running binary32 divider S = num2 / num1 (truncating; round-to-nearest-even
// when FP_DIV_RNE_EN is defined). One result every ITER+3 cycles.
module fp_div
    import fp_pkg::*;
#(
    parameter int ITER = 26
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] num1,
    input  logic [31:0] num2,
    output logic [31:0] S
);

    fp32_t a;
    fp32_t b;
    assign a = num2;
    assign b = num1;

    state_t             state;
    logic               sign_r;
    logic signed [9:0]  exp_r;
    logic               spec_r;
    logic [31:0]        spec_res_r;
    logic [ITER-2:0]    qn_r;
    logic               sticky_r;

    logic               sign;
    logic signed [9:0]  exp_calc;
    logic               spec;
    logic [31:0]        spec_res;
    logic [ITER-1:0]    quo;
    logic               sticky;
    logic               done;
    logic [22:0]        frac_f;
    logic signed [9:0]  exp_f;

    assign sign     = a.sign ^ b.sign;
    assign exp_calc = $signed({2'b00, a.exp}) - $signed({2'b00, b.exp}) + 10'(EXP_BIAS);

    always_comb begin
        spec     = 1'b1;
        spec_res = QNAN;
        if (is_nan(a) || is_nan(b) || (is_zero(a) && is_zero(b)) || (is_inf(a) && is_inf(b)))
            spec_res = QNAN;
        else if (is_zero(b) || is_inf(a))
            spec_res = {sign, POS_INF[30:0]};
        else if (is_inf(b) || is_zero(a))
            spec_res = {sign, 31'd0};
        else begin
            spec     = 1'b0;
            spec_res = '0;
        end
    end

    fp_div_mant #(.ITER(ITER)) u_mant (
        .clk      (clk),
        .rstn     (rstn),
        .start    ((state == LOAD) && !spec),
        .dividend ({1'b1, a.man}),
        .divisor  ({1'b1, b.man}),
        .quo      (quo),
        .sticky   (sticky),
        .done     (done)
    );

`ifdef FP_DIV_RNE_EN
    // Returns {exponent, fraction}; a fraction carry-out renormalises to 1.0 * 2^(e+1).
    function automatic logic [32:0] round_rne(input logic signed [9:0] e,
                                              input logic [24:0] q,
                                              input logic stk);
        logic        up;
        logic [23:0] sum;
        up  = q[1] && (q[0] || stk || q[2]);
        sum = {1'b0, q[24:2]} + {23'd0, up};
        return {e + (sum[23] ? 10'sd1 : 10'sd0), sum[22:0]};
    endfunction

    assign {exp_f, frac_f} = round_rne(exp_r, qn_r, sticky_r);
`else
    assign frac_f = qn_r[ITER-2:2];
    assign exp_f  = exp_r;

    logic unused_grs;
    assign unused_grs = ^{qn_r[1:0], sticky_r};
`endif

    function automatic logic [31:0] range_pack(input logic sgn,
                                               input logic signed [9:0] e,
                                               input logic [22:0] f);
        if (e >= 10'sd255) return {sgn, POS_INF[30:0]};
        if (e <= 10'sd0)   return {sgn, 31'd0};
        return {sgn, e[7:0], f};
    endfunction

    always_ff @(posedge clk) begin
        if (rstn) begin
            state      <= LOAD;
            S          <= '0;
            sign_r     <= 1'b0;
            exp_r      <= '0;
            spec_r     <= 1'b0;
            spec_res_r <= '0;
            qn_r       <= '0;
            sticky_r   <= 1'b0;
        end else begin
            case (state)
                // Capture operands; specials skip the iterative divide entirely.
                LOAD: begin
                    sign_r     <= sign;
                    exp_r      <= exp_calc;
                    spec_r     <= spec;
                    spec_res_r <= spec_res;
                    state      <= spec ? PACK : DIV;
                end
                DIV: begin
                    if (done) state <= NORM;
                end
                // Quotient lies in (0.5, 2); drop the hidden bit after normalising.
                NORM: begin
                    if (quo[ITER-1]) begin
                        qn_r <= quo[ITER-2:0];
                    end else begin
                        qn_r  <= {quo[ITER-3:0], 1'b0};
                        exp_r <= exp_r - 10'sd1;
                    end
                    sticky_r <= sticky;
                    state    <= PACK;
                end
                PACK: begin
                    S     <= spec_r ? spec_res_r : range_pack(sign_r, exp_f, frac_f);
                    state <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div.sv
// Directed self-checking bench for fp_div (quotient S = num2 / num1).
module tb_fp_div;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] num1;
    logic [31:0] num2;
    wire  [31:0] S;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_div dut (
        .clk  (clk),
        .rstn (rstn),
        .num1 (num1),
        .num2 (num2),
        .S    (S)
    );

`ifdef FP_DIV_RNE_EN
    localparam logic [31:0] ONE_THIRD = 32'h3EAA_AAAB;
`else
    localparam logic [31:0] ONE_THIRD = 32'h3EAA_AAAA;
`endif

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Bounded wait for S to take value v; n is the cycle count, or -1 on timeout.
    task automatic wait_for(input logic [31:0] v, input int budget, output int n);
        int i;
        i = 0;
        n = -1;
        while (n < 0 && i < budget) begin
            tick(1);
            i++;
            if (S === v) n = i;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        num2 = 32'h3E9E_B852;
        num1 = 32'h3F8F_5C29;
        tick(2);
        checks++;
        if (S !== 32'h0) begin
            failures++;
            $display("FAIL reset_S got=%h want=%h", S, 32'h0);
        end
    endtask

    task automatic test_basic_latency();
        int bad;
        rstn = 1'b0;
        tick(28);
        checks++;
        if (S !== 32'h0) begin
            failures++;
            $display("FAIL basic_pre_latency got=%h want=%h", S, 32'h0);
        end
        tick(1);
        checks++;
        if (S !== 32'h3E8D_B6DB) begin
            failures++;
            $display("FAIL basic_result got=%h want=%h", S, 32'h3E8D_B6DB);
        end
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (S !== 32'h3E8D_B6DB) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL basic_stable bad_cycles=%0d want=0", bad);
        end
    endtask

    task automatic test_midrun_change();
        int held_bad;
        int n;
        int i;
        tick(5);
        num2 = 32'h3F8E_147B;
        num1 = 32'h3F81_47AE;
        held_bad = 0;
        n = -1;
        i = 0;
        while (n < 0 && i < 58) begin
            tick(1);
            i++;
            if (S === 32'h3F8C_AC5B) n = i;
            else if (S !== 32'h3E8D_B6DB) held_bad++;
        end
        checks++;
        if (held_bad !== 0) begin
            failures++;
            $display("FAIL midrun_hold bad_cycles=%0d want=0", held_bad);
        end
        checks++;
        if (n < 0) begin
            failures++;
            $display("FAIL midrun_result got=%h want=%h within 58", S, 32'h3F8C_AC5B);
        end
    endtask

    task automatic test_sign();
        int n;
        num2 = 32'h4040_0000;
        num1 = 32'hC000_0000;
        wait_for(32'hBFC0_0000, 60, n);
        checks++;
        if (n < 0) begin
            failures++;
            $display("FAIL sign_neg got=%h want=%h", S, 32'hBFC0_0000);
        end
    endtask

    task automatic test_special();
        logic [31:0] t_n1  [9] = '{32'h0000_0000, 32'h0000_0000, 32'hFF80_0000,
                                   32'h7F80_0000, 32'h4000_0000, 32'h3F80_0000,
                                   32'hC000_0000, 32'h3F80_0000, 32'h0000_0001};
        logic [31:0] t_n2  [9] = '{32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000,
                                   32'h7F80_0000, 32'hFF80_0000, 32'hFFC1_2345,
                                   32'h0000_0000, 32'h0040_0000, 32'hBF80_0000};
        logic [31:0] t_exp [9] = '{32'h7F80_0000, 32'h7FC0_0000, 32'h8000_0000,
                                   32'h7FC0_0000, 32'hFF80_0000, 32'h7FC0_0000,
                                   32'h8000_0000, 32'h0000_0000, 32'hFF80_0000};
        int n;
        for (int k = 0; k < 9; k++) begin
            num1 = t_n1[k];
            num2 = t_n2[k];
            wait_for(t_exp[k], 60, n);
            checks++;
            if (n < 0) begin
                failures++;
                $display("FAIL special_%0d got=%h want=%h", k, S, t_exp[k]);
            end
        end
    endtask

    task automatic test_range();
        int n;
        num2 = 32'h7F00_0000;
        num1 = 32'h0080_0000;
        wait_for(32'h7F80_0000, 60, n);
        checks++;
        if (n < 0) begin
            failures++;
            $display("FAIL overflow got=%h want=%h", S, 32'h7F80_0000);
        end
        num2 = 32'h0080_0000;
        num1 = 32'h7F00_0000;
        wait_for(32'h0000_0000, 60, n);
        checks++;
        if (n < 0) begin
            failures++;
            $display("FAIL underflow got=%h want=%h", S, 32'h0000_0000);
        end
    endtask

    task automatic test_rounding();
        int n;
        num2 = 32'h3F80_0000;
        num1 = 32'h4040_0000;
        wait_for(ONE_THIRD, 60, n);
        checks++;
        if (n < 0) begin
            failures++;
            $display("FAIL one_third got=%h want=%h", S, ONE_THIRD);
        end
    endtask

    task automatic test_reset_mid();
        tick(10);
        rstn = 1'b1;
        tick(1);
        checks++;
        if (S !== 32'h0) begin
            failures++;
            $display("FAIL midreset_clear got=%h want=%h", S, 32'h0);
        end
        rstn = 1'b0;
        tick(28);
        checks++;
        if (S !== 32'h0) begin
            failures++;
            $display("FAIL midreset_pre got=%h want=%h", S, 32'h0);
        end
        tick(1);
        checks++;
        if (S !== ONE_THIRD) begin
            failures++;
            $display("FAIL midreset_result got=%h want=%h", S, ONE_THIRD);
        end
    endtask

    initial begin
        rstn = 1'b1;
        num1 = 32'h0;
        num2 = 32'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic_latency();
        test_midrun_change();
        test_sign();
        test_special();
        test_range();
        test_rounding();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
